// File: rtl/fpu_accumulator_if.sv
// Product-in / sum-out stb/ack handshake bundle for the FP32 accumulator.
// master drives products and the sum ack; slave is the accumulator itself.
interface fpu_accumulator_if;
    logic [31:0] input_p;
    logic        input_p_stb;
    logic        input_p_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    modport master (
        output input_p,
        output input_p_stb,
        output output_z_ack,
        input  input_p_ack,
        input  output_z,
        input  output_z_stb
    );

    modport slave (
        input  input_p,
        input  input_p_stb,
        input  output_z_ack,
        output input_p_ack,
        output output_z,
        output output_z_stb
    );
endinterface

// File: rtl/fpu_accumulator.sv
// Sequential IEEE-754 FP32 accumulator: sums LEN products (RNE, denormals
// supported) and hands the sum downstream before restarting from +0.
module fpu_accumulator #(
    parameter int unsigned LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    fpu_accumulator_if.slave    bus
);

    localparam logic [7:0] LEN_C = 8'(LEN);

    typedef enum logic [3:0] {
        GET_P, UNPACK, SPECIAL_CASES, ALIGN, ADD_0, ADD_1,
        NORMALISE_1, NORMALISE_2, ROUND, PACK, CHECK_COUNT, PUT_Z
    } state_t;

    state_t             state_r, state_n;
    logic [31:0]        acc_r, acc_n;
    logic [31:0]        p_r, p_n;
    logic [7:0]         count_r, count_n;
    logic [26:0]        a_m_r, a_m_n, b_m_r, b_m_n;
    logic signed [9:0]  a_e_r, a_e_n, b_e_r, b_e_n, z_e_r, z_e_n;
    logic               a_s_r, a_s_n, b_s_r, b_s_n, z_s_r, z_s_n;
    logic [23:0]        z_m_r, z_m_n;
    logic               guard_r, guard_n, rnd_r, rnd_n, sticky_r, sticky_n;
    logic [27:0]        sum_r, sum_n;
    logic               ack_r, ack_n, stb_r, stb_n;
    logic [31:0]        out_r, out_n;

    logic               a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic signed [9:0]  e_diff_s;
    logic [7:0]         z_bexp_s;

    // Operand classification on the raw unpacked fields (hidden bit not yet set)
    assign a_nan_s  = (a_e_r == 10'sd128)  && (a_m_r[26:3] != 24'd0);
    assign b_nan_s  = (b_e_r == 10'sd128)  && (b_m_r[26:3] != 24'd0);
    assign a_inf_s  = (a_e_r == 10'sd128)  && (a_m_r[26:3] == 24'd0);
    assign b_inf_s  = (b_e_r == 10'sd128)  && (b_m_r[26:3] == 24'd0);
    assign a_zero_s = (a_e_r == -10'sd127) && (a_m_r[26:3] == 24'd0);
    assign b_zero_s = (b_e_r == -10'sd127) && (b_m_r[26:3] == 24'd0);
    assign e_diff_s = a_e_r - b_e_r;
    assign z_bexp_s = z_e_r[7:0] + 8'd127;

    assign bus.input_p_ack  = ack_r;
    assign bus.output_z_stb = stb_r;
    assign bus.output_z     = out_r;

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= GET_P;
            acc_r    <= 32'd0;
            p_r      <= 32'd0;
            count_r  <= 8'd0;
            a_m_r    <= 27'd0;
            b_m_r    <= 27'd0;
            a_e_r    <= 10'sd0;
            b_e_r    <= 10'sd0;
            z_e_r    <= 10'sd0;
            a_s_r    <= 1'b0;
            b_s_r    <= 1'b0;
            z_s_r    <= 1'b0;
            z_m_r    <= 24'd0;
            guard_r  <= 1'b0;
            rnd_r    <= 1'b0;
            sticky_r <= 1'b0;
            sum_r    <= 28'd0;
            ack_r    <= 1'b0;
            stb_r    <= 1'b0;
            out_r    <= 32'd0;
        end else begin
            state_r  <= state_n;
            acc_r    <= acc_n;
            p_r      <= p_n;
            count_r  <= count_n;
            a_m_r    <= a_m_n;
            b_m_r    <= b_m_n;
            a_e_r    <= a_e_n;
            b_e_r    <= b_e_n;
            z_e_r    <= z_e_n;
            a_s_r    <= a_s_n;
            b_s_r    <= b_s_n;
            z_s_r    <= z_s_n;
            z_m_r    <= z_m_n;
            guard_r  <= guard_n;
            rnd_r    <= rnd_n;
            sticky_r <= sticky_n;
            sum_r    <= sum_n;
            ack_r    <= ack_n;
            stb_r    <= stb_n;
            out_r    <= out_n;
        end
    end

    // Next-state and datapath update for the multi-cycle add sequence
    always_comb begin
        state_n  = state_r;
        acc_n    = acc_r;
        p_n      = p_r;
        count_n  = count_r;
        a_m_n    = a_m_r;
        b_m_n    = b_m_r;
        a_e_n    = a_e_r;
        b_e_n    = b_e_r;
        z_e_n    = z_e_r;
        a_s_n    = a_s_r;
        b_s_n    = b_s_r;
        z_s_n    = z_s_r;
        z_m_n    = z_m_r;
        guard_n  = guard_r;
        rnd_n    = rnd_r;
        sticky_n = sticky_r;
        sum_n    = sum_r;
        ack_n    = ack_r;
        stb_n    = stb_r;
        out_n    = out_r;

        case (state_r)
            GET_P: begin
                if (ack_r && bus.input_p_stb) begin
                    p_n     = bus.input_p;
                    ack_n   = 1'b0;
                    state_n = UNPACK;
                end else begin
                    ack_n   = 1'b1;
                end
            end
            UNPACK: begin
                a_m_n   = {acc_r[22:0], 3'b000};
                b_m_n   = {p_r[22:0], 3'b000};
                a_e_n   = $signed({2'b00, acc_r[30:23]}) - 10'sd127;
                b_e_n   = $signed({2'b00, p_r[30:23]}) - 10'sd127;
                a_s_n   = acc_r[31];
                b_s_n   = p_r[31];
                state_n = SPECIAL_CASES;
            end
            SPECIAL_CASES: begin
                if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_s_r != b_s_r))) begin
                    acc_n   = 32'hFFC0_0000;
                    state_n = CHECK_COUNT;
                end else if (a_inf_s) begin
                    acc_n   = {a_s_r, 8'hFF, 23'd0};
                    state_n = CHECK_COUNT;
                end else if (b_inf_s) begin
                    acc_n   = {b_s_r, 8'hFF, 23'd0};
                    state_n = CHECK_COUNT;
                end else if (a_zero_s && b_zero_s) begin
                    acc_n   = {a_s_r & b_s_r, 31'd0};
                    state_n = CHECK_COUNT;
                end else if (a_zero_s) begin
                    acc_n   = p_r;
                    state_n = CHECK_COUNT;
                end else if (b_zero_s) begin
                    acc_n   = acc_r;
                    state_n = CHECK_COUNT;
                end else begin
                    if (a_e_r == -10'sd127) begin
                        a_e_n = -10'sd126;
                    end else begin
                        a_m_n[26] = 1'b1;
                    end
                    if (b_e_r == -10'sd127) begin
                        b_e_n = -10'sd126;
                    end else begin
                        b_m_n[26] = 1'b1;
                    end
                    state_n = ALIGN;
                end
            end
            ALIGN: begin
                // Beyond 26 places only the sticky OR survives, so collapse in one step
                if (e_diff_s > 10'sd26) begin
                    b_m_n = {26'd0, |b_m_r};
                    b_e_n = a_e_r;
                end else if (e_diff_s > 10'sd0) begin
                    b_m_n = {1'b0, b_m_r[26:2], b_m_r[1] | b_m_r[0]};
                    b_e_n = b_e_r + 10'sd1;
                end else if (e_diff_s < -10'sd26) begin
                    a_m_n = {26'd0, |a_m_r};
                    a_e_n = b_e_r;
                end else if (e_diff_s < 10'sd0) begin
                    a_m_n = {1'b0, a_m_r[26:2], a_m_r[1] | a_m_r[0]};
                    a_e_n = a_e_r + 10'sd1;
                end else begin
                    state_n = ADD_0;
                end
            end
            ADD_0: begin
                z_e_n = a_e_r;
                if (a_s_r == b_s_r) begin
                    sum_n   = {1'b0, a_m_r} + {1'b0, b_m_r};
                    z_s_n   = a_s_r;
                    state_n = ADD_1;
                end else if (a_m_r == b_m_r) begin
                    acc_n   = 32'd0;
                    state_n = CHECK_COUNT;
                end else if (a_m_r > b_m_r) begin
                    sum_n   = {1'b0, a_m_r} - {1'b0, b_m_r};
                    z_s_n   = a_s_r;
                    state_n = ADD_1;
                end else begin
                    sum_n   = {1'b0, b_m_r} - {1'b0, a_m_r};
                    z_s_n   = b_s_r;
                    state_n = ADD_1;
                end
            end
            ADD_1: begin
                if (sum_r[27]) begin
                    z_m_n    = sum_r[27:4];
                    guard_n  = sum_r[3];
                    rnd_n    = sum_r[2];
                    sticky_n = sum_r[1] | sum_r[0];
                    z_e_n    = z_e_r + 10'sd1;
                end else begin
                    z_m_n    = sum_r[26:3];
                    guard_n  = sum_r[2];
                    rnd_n    = sum_r[1];
                    sticky_n = sum_r[0];
                end
                state_n = NORMALISE_1;
            end
            NORMALISE_1: begin
                if (!z_m_r[23] && (z_e_r > -10'sd126)) begin
                    z_e_n   = z_e_r - 10'sd1;
                    z_m_n   = {z_m_r[22:0], guard_r};
                    guard_n = rnd_r;
                    rnd_n   = 1'b0;
                end else begin
                    state_n = NORMALISE_2;
                end
            end
            NORMALISE_2: begin
                if (z_e_r < -10'sd126) begin
                    z_e_n    = z_e_r + 10'sd1;
                    z_m_n    = {1'b0, z_m_r[23:1]};
                    guard_n  = z_m_r[0];
                    rnd_n    = guard_r;
                    sticky_n = sticky_r | rnd_r;
                end else begin
                    state_n = ROUND;
                end
            end
            ROUND: begin
                if (guard_r && (rnd_r || sticky_r || z_m_r[0])) begin
                    z_m_n = z_m_r + 24'd1;
                    if (z_m_r == 24'hFF_FFFF) begin
                        z_e_n = z_e_r + 10'sd1;
                    end else begin
                        z_e_n = z_e_r;
                    end
                end else begin
                    z_m_n = z_m_r;
                end
                state_n = PACK;
            end
            PACK: begin
                if (z_e_r > 10'sd127) begin
                    acc_n = {z_s_r, 8'hFF, 23'd0};
                end else if ((z_e_r == -10'sd126) && !z_m_r[23]) begin
                    acc_n = {z_s_r, 8'd0, z_m_r[22:0]};
                end else begin
                    acc_n = {z_s_r, z_bexp_s, z_m_r[22:0]};
                end
                state_n = CHECK_COUNT;
            end
            CHECK_COUNT: begin
                count_n = count_r + 8'd1;
                if (count_n == LEN_C) begin
                    out_n   = acc_r;
                    stb_n   = 1'b1;
                    state_n = PUT_Z;
                end else begin
                    state_n = GET_P;
                end
            end
            PUT_Z: begin
                if (stb_r && bus.output_z_ack) begin
                    stb_n   = 1'b0;
                    acc_n   = 32'd0;
                    count_n = 8'd0;
                    state_n = GET_P;
                end else begin
                    stb_n   = 1'b1;
                end
            end
            default: begin
                state_n = GET_P;
            end
        endcase
    end

endmodule

// File: tb/tb_fpu_accumulator.sv
// Directed self-checking bench for fpu_accumulator (LEN = 4).
module tb_fpu_accumulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_accumulator_if bus ();

    fpu_accumulator #(.LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] terms [10][4];
    logic [31:0] expv  [10];
    int          gaps  [4];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    task automatic send_term(input logic [31:0] val, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        bus.input_p     = val;
        bus.input_p_stb = 1'b1;
        n = 0;
        while (bus.input_p_ack !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check_val("p_ack_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        bus.input_p_stb = 1'b0;
    endtask

    task automatic get_result(input logic [31:0] exp_v, input string tag, input int hold);
        int n;
        n = 0;
        while (bus.output_z_stb !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) check_val({tag, "_stb_timeout"}, 32'(n), 32'd0);
        check_val(tag, bus.output_z, exp_v);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_val({tag, "_hold_stb"}, {31'd0, bus.output_z_stb}, 32'd1);
            check_val({tag, "_hold_z"}, bus.output_z, exp_v);
            check_val({tag, "_hold_p_ack"}, {31'd0, bus.input_p_ack}, 32'd0);
        end
        bus.output_z_ack = 1'b1;
        @(posedge clk); #1;
        bus.output_z_ack = 1'b0;
        check_val({tag, "_stb_drop"}, {31'd0, bus.output_z_stb}, 32'd0);
    endtask

    initial begin
        terms[0] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000}; expv[0] = 32'h4120_0000;
        terms[1] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h8000_0000}; expv[1] = 32'h0000_0000;
        terms[2] = '{32'h3F80_0000, 32'h3380_0000, 32'h0000_0000, 32'h0000_0000}; expv[2] = 32'h3F80_0000;
        terms[3] = '{32'h3F80_0001, 32'h3380_0000, 32'h0000_0000, 32'h0000_0000}; expv[3] = 32'h3F80_0002;
        terms[4] = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h0000_0000, 32'h0000_0000}; expv[4] = 32'h7F80_0000;
        terms[5] = '{32'h7F80_0000, 32'hFF80_0000, 32'h0000_0000, 32'h0000_0000}; expv[5] = 32'hFFC0_0000;
        terms[6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001}; expv[6] = 32'h0000_0004;
        terms[7] = '{32'h0080_0000, 32'h8000_0001, 32'h0000_0000, 32'h0000_0000}; expv[7] = 32'h007F_FFFF;
        terms[8] = '{32'h3FC0_0000, 32'hBFA0_0000, 32'h0000_0000, 32'h0000_0000}; expv[8] = 32'h3E80_0000;
        terms[9] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000}; expv[9] = 32'h4120_0000;
        gaps = '{0, 5, 2, 4};

        rst              = 1'b0;
        bus.input_p      = 32'd0;
        bus.input_p_stb  = 1'b0;
        bus.output_z_ack = 1'b0;
        #1;
        check_val("rst_p_ack", {31'd0, bus.input_p_ack}, 32'd0);
        check_val("rst_z_stb", {31'd0, bus.output_z_stb}, 32'd0);
        check_val("rst_z", bus.output_z, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 4; i++) begin
                send_term(terms[v][i], (v == 9) ? gaps[i] : 0);
            end
            get_result(expv[v], $sformatf("vec%0d", v), (v == 0) ? 10 : 0);
        end

        // Abort a partial sum while the accumulator waits for its third term
        send_term(32'h3F80_0000, 0);
        send_term(32'h3F80_0000, 0);
        begin
            int n;
            n = 0;
            while (bus.input_p_ack !== 1'b1 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 200) check_val("mid_ack_timeout", 32'(n), 32'd0);
        end
        #2;
        rst = 1'b0;
        #1;
        check_val("mid_rst_p_ack", {31'd0, bus.input_p_ack}, 32'd0);
        check_val("mid_rst_z_stb", {31'd0, bus.output_z_stb}, 32'd0);
        check_val("mid_rst_z", bus.output_z, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            send_term(32'h3F80_0000, 0);
        end
        get_result(32'h4080_0000, "after_rst", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
